// File: rtl/r_pipe_hazard_ctrl_if.sv
// ID-stage hazard bus between the decode stage (master) and r_pipe_hazard_ctrl (slave).
// Valid/ready note: the ID instruction issues in a cycle where id_valid=1 and stall=0; ex_valid marks it one cycle later.
interface r_pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_we;
    logic              flush;
    logic              stall;
    logic              ex_valid;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_we, flush,
        input  stall, ex_valid, fwd_a, fwd_b, issue_cnt, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_we, flush,
        output stall, ex_valid, fwd_a, fwd_b, issue_cnt, stall_cnt
    );
endinterface

// File: rtl/r_pipe_hazard_ctrl.sv
// Hazard scheduler beside ID: scoreboard of rd in EX/MEM/WB, stall/bubble decision, forwarding selects.
// Define R_PIPE_FORWARD_EN to enable operand forwarding (stall tied low); otherwise a full interlock is used.
module r_pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic                clk,
    input logic                rst_n,
    r_pipe_hazard_ctrl_if.slave bus
);

    logic              r_ex_v, r_mem_v, r_wb_v;
    logic [REG_AW-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
    logic              r_ex_valid;
    logic [CNT_W-1:0]  r_issue_cnt, r_stall_cnt;

    logic w_a_ex, w_a_mem, w_a_wb;
    logic w_b_ex, w_b_mem, w_b_wb;
    logic w_stall, w_issue, w_issue_ok;

    // Register 0 is hardwired, so it can never be a true dependency.
    function automatic logic f_match(input logic v, input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] s);
        return v && (rd == s) && (s != '0);
    endfunction

    assign w_a_ex  = f_match(r_ex_v,  r_ex_rd,  bus.id_rs);
    assign w_a_mem = f_match(r_mem_v, r_mem_rd, bus.id_rs);
    assign w_a_wb  = f_match(r_wb_v,  r_wb_rd,  bus.id_rs);
    assign w_b_ex  = f_match(r_ex_v,  r_ex_rd,  bus.id_rt);
    assign w_b_mem = f_match(r_mem_v, r_mem_rd, bus.id_rt);
    assign w_b_wb  = f_match(r_wb_v,  r_wb_rd,  bus.id_rt);

`ifdef R_PIPE_FORWARD_EN
    logic [1:0] r_fwd_a, r_fwd_b;
    logic [1:0] w_sel_a, w_sel_b;

    function automatic logic [1:0] f_sel(input logic h_ex, input logic h_mem, input logic h_wb);
        if (h_ex)       return 2'b01;
        else if (h_mem) return 2'b10;
        else if (h_wb)  return 2'b11;
        else            return 2'b00;
    endfunction

    assign w_stall = 1'b0;
    assign w_sel_a = f_sel(w_a_ex, w_a_mem, w_a_wb);
    assign w_sel_b = f_sel(w_b_ex, w_b_mem, w_b_wb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_a <= 2'b00;
            r_fwd_b <= 2'b00;
        end else begin
            r_fwd_a <= w_issue_ok ? w_sel_a : 2'b00;
            r_fwd_b <= w_issue_ok ? w_sel_b : 2'b00;
        end
    end

    assign bus.fwd_a = r_fwd_a;
    assign bus.fwd_b = r_fwd_b;
`else
    logic w_hazard;

    // No write-through register file: a match in WB still has to wait.
    assign w_hazard  = w_a_ex | w_a_mem | w_a_wb | w_b_ex | w_b_mem | w_b_wb;
    assign w_stall   = bus.id_valid & ~bus.flush & w_hazard;
    assign bus.fwd_a = 2'b00;
    assign bus.fwd_b = 2'b00;
`endif

    assign w_issue    = bus.id_valid & ~w_stall;
    assign w_issue_ok = w_issue & ~bus.flush;

    // Scoreboard shifts every cycle; the pipeline past ID never freezes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_v   <= 1'b0;
            r_mem_v  <= 1'b0;
            r_wb_v   <= 1'b0;
            r_ex_rd  <= '0;
            r_mem_rd <= '0;
            r_wb_rd  <= '0;
        end else begin
            r_ex_rd  <= bus.id_rd;
            r_mem_rd <= r_ex_rd;
            r_wb_rd  <= r_mem_rd;
            if (bus.flush) begin
                r_ex_v  <= 1'b0;
                r_mem_v <= 1'b0;
                r_wb_v  <= 1'b0;
            end else begin
                r_ex_v  <= w_issue & bus.id_we & (bus.id_rd != '0);
                r_mem_v <= r_ex_v;
                r_wb_v  <= r_mem_v;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_ex_valid <= w_issue_ok;
            if (w_issue_ok && (r_issue_cnt != '1))
                r_issue_cnt <= r_issue_cnt + 1'b1;
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.stall     = w_stall;
    assign bus.ex_valid  = r_ex_valid;
    assign bus.issue_cnt = r_issue_cnt;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_r_pipe_hazard_ctrl.sv
// Bench for r_pipe_hazard_ctrl: cycle vectors with a registered-output scoreboard, plus reset and saturation sequences.
// Expectations follow the build: R_PIPE_FORWARD_EN selects the forwarding vector table.
module tb_r_pipe_hazard_ctrl;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt, rd;
        logic       we, fl;
        logic       exp_stall, exp_exv;
        logic [1:0] exp_fa, exp_fb;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   m_issue;
    int   m_stall;
    vec_t vecs[$];
    logic [4:0] exp_q[$];

    r_pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();

    r_pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add_vec(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic we, input logic fl,
                           input logic es, input logic ev, input logic [1:0] fa,
                           input logic [1:0] fb);
        vec_t t;
        t.v = v; t.rs = rs; t.rt = rt; t.rd = rd; t.we = we; t.fl = fl;
        t.exp_stall = es; t.exp_exv = ev; t.exp_fa = fa; t.exp_fb = fb;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic we, input logic fl);
        bus.id_valid = v;
        bus.id_rs    = rs;
        bus.id_rt    = rt;
        bus.id_rd    = rd;
        bus.id_we    = we;
        bus.flush    = fl;
    endtask

    task automatic apply(input vec_t t, input int idx);
        logic [4:0] got;
        logic [4:0] exp;
        @(negedge clk);
        drive(t.v, t.rs, t.rt, t.rd, t.we, t.fl);
        #1;
        check($sformatf("stall[%0d]", idx), {31'd0, bus.stall}, {31'd0, t.exp_stall});
        exp_q.push_back({t.exp_exv, t.exp_fa, t.exp_fb});
        if (t.v && !t.exp_stall && !t.fl) m_issue++;
        if (t.exp_stall) m_stall++;
        @(posedge clk);
        #1;
        got = {bus.ex_valid, bus.fwd_a, bus.fwd_b};
        exp = exp_q.pop_front();
        check($sformatf("exv_fwd[%0d]", idx), {27'd0, got}, {27'd0, exp});
        check($sformatf("issue_cnt[%0d]", idx), {16'd0, bus.issue_cnt}, m_issue);
        check($sformatf("stall_cnt[%0d]", idx), {16'd0, bus.stall_cnt}, m_stall);
    endtask

    initial begin
        n_vec = 0; n_err = 0; m_issue = 0; m_stall = 0;
        rst_n = 1'b0;
        drive(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0);

`ifdef R_PIPE_FORWARD_EN
        //       v  rs  rt  rd  we fl  stall exv fa     fb
        add_vec(1, 1,  2,  3,  1, 0,  0,    1,  2'b00, 2'b00); // add $3
        add_vec(1, 3,  3,  5,  1, 0,  0,    1,  2'b01, 2'b01); // or  $5,$3,$3
        add_vec(1, 3,  0,  6,  1, 0,  0,    1,  2'b10, 2'b00); // and $6,$3,$0
        add_vec(1, 0,  3,  7,  1, 0,  0,    1,  2'b00, 2'b11); // xor $7,$0,$3
        add_vec(1, 1,  2,  8,  1, 0,  0,    1,  2'b00, 2'b00);
        add_vec(1, 1,  2,  8,  1, 0,  0,    1,  2'b00, 2'b00);
        add_vec(1, 8,  8,  9,  1, 0,  0,    1,  2'b01, 2'b01); // nearest $8 wins
        add_vec(1, 1,  2,  0,  1, 0,  0,    1,  2'b00, 2'b00);
        add_vec(1, 0,  0,  10, 1, 0,  0,    1,  2'b00, 2'b00); // $0 never forwards
        add_vec(1, 9,  9,  11, 1, 1,  0,    0,  2'b00, 2'b00); // flush kills issue
        add_vec(1, 9,  10, 12, 1, 0,  0,    1,  2'b00, 2'b00); // slots emptied
        add_vec(0, 12, 12, 13, 1, 0,  0,    0,  2'b00, 2'b00);
`else
        //       v  rs  rt  rd  we fl  stall exv fa     fb
        add_vec(1, 1,  2,  3,  1, 0,  0,    1,  2'b00, 2'b00); // add $3,$1,$2
        add_vec(1, 3,  1,  4,  1, 0,  1,    0,  2'b00, 2'b00); // sub $4,$3,$1
        add_vec(1, 3,  1,  4,  1, 0,  1,    0,  2'b00, 2'b00);
        add_vec(1, 3,  1,  4,  1, 0,  1,    0,  2'b00, 2'b00);
        add_vec(1, 3,  1,  4,  1, 0,  0,    1,  2'b00, 2'b00); // issues in cycle 4
        add_vec(1, 1,  2,  7,  1, 0,  0,    1,  2'b00, 2'b00); // distance 2
        add_vec(1, 1,  2,  8,  1, 0,  0,    1,  2'b00, 2'b00);
        add_vec(1, 7,  2,  11, 1, 0,  1,    0,  2'b00, 2'b00);
        add_vec(1, 7,  2,  11, 1, 0,  1,    0,  2'b00, 2'b00);
        add_vec(1, 7,  2,  11, 1, 0,  0,    1,  2'b00, 2'b00);
        add_vec(1, 1,  2,  9,  1, 0,  0,    1,  2'b00, 2'b00); // distance 3
        add_vec(1, 1,  2,  10, 1, 0,  0,    1,  2'b00, 2'b00);
        add_vec(1, 1,  2,  12, 1, 0,  0,    1,  2'b00, 2'b00);
        add_vec(1, 1,  9,  0,  0, 0,  1,    0,  2'b00, 2'b00);
        add_vec(1, 1,  9,  0,  0, 0,  0,    1,  2'b00, 2'b00);
        add_vec(1, 1,  2,  13, 1, 0,  0,    1,  2'b00, 2'b00); // distance 4
        add_vec(1, 1,  2,  14, 1, 0,  0,    1,  2'b00, 2'b00);
        add_vec(1, 1,  2,  15, 1, 0,  0,    1,  2'b00, 2'b00);
        add_vec(1, 1,  2,  16, 1, 0,  0,    1,  2'b00, 2'b00);
        add_vec(1, 13, 2,  17, 1, 0,  0,    1,  2'b00, 2'b00);
        add_vec(1, 1,  2,  0,  1, 0,  0,    1,  2'b00, 2'b00); // writer of $0
        add_vec(1, 0,  0,  18, 1, 0,  0,    1,  2'b00, 2'b00);
        add_vec(0, 18, 18, 19, 1, 0,  0,    0,  2'b00, 2'b00); // no instruction
        add_vec(1, 1,  2,  20, 0, 0,  0,    1,  2'b00, 2'b00); // we=0 producer
        add_vec(1, 20, 20, 19, 1, 0,  0,    1,  2'b00, 2'b00);
        add_vec(1, 1,  2,  21, 1, 0,  0,    1,  2'b00, 2'b00);
        add_vec(1, 21, 2,  22, 1, 0,  1,    0,  2'b00, 2'b00);
        add_vec(1, 21, 2,  22, 1, 1,  0,    0,  2'b00, 2'b00); // flush drops stall
        add_vec(1, 21, 2,  22, 1, 0,  0,    1,  2'b00, 2'b00);
`endif

        // Reset with a live ID instruction.
        #3;
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_exv", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_fwd", {28'd0, bus.fwd_a, bus.fwd_b}, 32'd0);
        check("rst_issue_cnt", {16'd0, bus.issue_cnt}, 32'd0);
        check("rst_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);
        check("sb_empty", exp_q.size(), 32'd0);

`ifndef R_PIPE_FORWARD_EN
        // Asynchronous reset in the middle of a stall clears it at once.
        @(negedge clk);
        drive(1'b1, 5'd1, 5'd2, 5'd25, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 5'd25, 5'd25, 5'd26, 1'b1, 1'b0);
        #1;
        check("midstall_pre", {31'd0, bus.stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midstall_rst", {31'd0, bus.stall}, 32'd0);
        check("midstall_exv", {31'd0, bus.ex_valid}, 32'd0);
        check("midstall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
`endif

        // Saturation: 65534 issues reach 0xFFFE, three more must hold at 0xFFFF.
        rst_n = 1'b0;
        @(negedge clk);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", {16'd0, bus.issue_cnt}, 32'h0000_FFFE);
        repeat (3) @(posedge clk);
        #1;
        check("sat_ffff", {16'd0, bus.issue_cnt}, 32'h0000_FFFF);
        check("sat_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
